// File: rtl/imem_load_ctrl.sv
// Instruction memory front-end: CPU fetch path with PC legality checks, and a
// valid/ready program loader that writes words from address 0 while stalling the CPU.
module imem_load_ctrl #(
    parameter int          ADDR_W = 6,
    parameter int          DEPTH  = 64,
    parameter logic [31:0] NOP    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    input  logic [31:0]       cpu_pc,
    output logic [31:0]       cpu_instr,
    output logic              cpu_stall,
    output logic              fetch_fault,
    output logic [31:0]       fault_pc,
    output logic              load_err,
    output logic              load_done
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    // Word-aligned and inside the memory window.
    function automatic logic pc_is_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc[31:ADDR_W+2] == '0);
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W:0]   len_r;
    logic              fetch_fault_r;
    logic [31:0]       fault_pc_r;
    logic              load_err_r;

    logic pc_legal_s;
    logic len_ok_s;
    logic start_ok_s;
    logic xfer_s;
    logic last_s;

    assign pc_legal_s = pc_is_legal(cpu_pc);
    assign len_ok_s   = (load_len != '0) && (load_len <= DEPTH_LEN);
    assign start_ok_s = (state_r == ST_RUN) && load_start && len_ok_s;
    assign xfer_s     = (state_r == ST_LOAD) && ld_valid;
    assign last_s     = ({1'b0, cnt_r} == (len_r - {{ADDR_W{1'b0}}, 1'b1}));

    // State register; reset aborts any load in progress without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (xfer_s && last_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_FLUSH: state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // State-decoded outputs; fetch data passes straight through only in RUN.
    always_comb begin
        cpu_stall = 1'b1;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        load_done = 1'b0;
        cpu_instr = NOP;
        case (state_r)
            ST_RUN: begin
                cpu_stall = 1'b0;
                if (pc_legal_s) begin
                    cpu_instr = mem_rdata;
                end else begin
                    cpu_instr = NOP;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                mem_we   = ld_valid;
            end
            ST_FLUSH: begin
                load_done = 1'b1;
            end
            default: begin
                cpu_stall = 1'b1;
            end
        endcase
    end

    // Load bookkeeping and sticky status flags; a legal load start clears the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r         <= '0;
            len_r         <= '0;
            fetch_fault_r <= 1'b0;
            fault_pc_r    <= 32'h0000_0000;
            load_err_r    <= 1'b0;
        end else if (start_ok_s) begin
            cnt_r         <= '0;
            len_r         <= load_len;
            fetch_fault_r <= 1'b0;
            fault_pc_r    <= 32'h0000_0000;
            load_err_r    <= 1'b0;
        end else begin
            // The final transfer leaves the counter on the last address so it never wraps.
            if (xfer_s && !last_s) begin
                cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == ST_RUN) && !pc_legal_s) begin
                fetch_fault_r <= 1'b1;
                if (!fetch_fault_r) begin
                    fault_pc_r <= cpu_pc;
                end else begin
                    fault_pc_r <= fault_pc_r;
                end
            end else begin
                fetch_fault_r <= fetch_fault_r;
                fault_pc_r    <= fault_pc_r;
            end
            if ((state_r == ST_RUN) && load_start && !len_ok_s) begin
                load_err_r <= 1'b1;
            end else begin
                load_err_r <= load_err_r;
            end
        end
    end

    assign mem_raddr   = cpu_pc[ADDR_W+1:2];
    assign mem_waddr   = cnt_r;
    assign mem_wdata   = ld_data;
    assign fetch_fault = fetch_fault_r;
    assign fault_pc    = fault_pc_r;
    assign load_err    = load_err_r;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural 64-word memory attached.
module tb_imem_load_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [6:0]  load_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        mem_we;
    logic [5:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [5:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic        load_err;
    logic        load_done;

    logic [31:0] tb_mem [64];
    int          wcnt;
    logic        use_ovr;
    logic [31:0] ovr_data;
    int          total;
    int          bad;
    int          base;
    int          diffs;

    imem_load_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .cpu_pc(cpu_pc),
        .cpu_instr(cpu_instr), .cpu_stall(cpu_stall), .fetch_fault(fetch_fault),
        .fault_pc(fault_pc), .load_err(load_err), .load_done(load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_waddr] <= mem_wdata;
            wcnt <= wcnt + 1;
        end
    end

    assign mem_rdata = use_ovr ? ovr_data : tb_mem[mem_raddr];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; load_start = 1'b0; load_len = 7'd0; ld_valid = 1'b0;
        ld_data = 32'h0; cpu_pc = 32'h0; use_ovr = 1'b1; ovr_data = 32'h0;
        #3;
        check_val("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check_val("rst_ready", {31'd0, ld_ready}, 32'd0);
        check_val("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check_val("rst_fpc", fault_pc, 32'h0);
        check_val("rst_lerr", {31'd0, load_err}, 32'd0);
        check_val("rst_done", {31'd0, load_done}, 32'd0);
        step(); step();
        rst_n = 1'b1;

        // Legal fetch
        cpu_pc = 32'h8; ovr_data = 32'h0010_0093; #1;
        check_val("raddr", {26'd0, mem_raddr}, 32'd2);
        check_val("instr", cpu_instr, 32'h0010_0093);
        check_val("run_stall", {31'd0, cpu_stall}, 32'd0);
        step();

        // Misaligned then out-of-range fetch; first fault wins
        cpu_pc = 32'h102; #1;
        check_val("nop_bad_pc", cpu_instr, NOP);
        step();
        check_val("fault_set", {31'd0, fetch_fault}, 32'd1);
        check_val("fault_pc", fault_pc, 32'h102);
        cpu_pc = 32'h104; #1;
        check_val("nop_range", cpu_instr, NOP);
        step();
        check_val("fault_pc_keep", fault_pc, 32'h102);
        cpu_pc = 32'h0;

        // Three-word load with a gap after the second word
        base = wcnt;
        load_start = 1'b1; load_len = 7'd3;
        step();
        load_start = 1'b0; #1;
        check_val("ld_stall", {31'd0, cpu_stall}, 32'd1);
        check_val("ld_ready", {31'd0, ld_ready}, 32'd1);
        check_val("ld_nop", cpu_instr, NOP);
        check_val("ld_fault_clr", {31'd0, fetch_fault}, 32'd0);
        check_val("ld_fpc_clr", fault_pc, 32'h0);
        ld_valid = 1'b1; ld_data = 32'hAAAA_0001; #1;
        check_val("we_a", {31'd0, mem_we}, 32'd1);
        check_val("addr_a", {26'd0, mem_waddr}, 32'd0);
        step();
        ld_data = 32'hBBBB_0002; load_start = 1'b1; load_len = 7'd0; #1;
        check_val("addr_b", {26'd0, mem_waddr}, 32'd1);
        step();
        load_start = 1'b0;
        check_val("start_ignored", {31'd0, load_err}, 32'd0);
        ld_valid = 1'b0; #1;
        check_val("gap_we", {31'd0, mem_we}, 32'd0);
        check_val("gap_stall", {31'd0, cpu_stall}, 32'd1);
        step();
        ld_valid = 1'b1; ld_data = 32'hCCCC_0003; #1;
        check_val("addr_c", {26'd0, mem_waddr}, 32'd2);
        step();
        check_val("flush_done", {31'd0, load_done}, 32'd1);
        check_val("flush_stall", {31'd0, cpu_stall}, 32'd1);
        check_val("flush_ready", {31'd0, ld_ready}, 32'd0);
        check_val("flush_we", {31'd0, mem_we}, 32'd0);
        step();
        ld_valid = 1'b0;
        check_val("run_done", {31'd0, load_done}, 32'd0);
        check_val("run_again", {31'd0, cpu_stall}, 32'd0);
        check_val("wr_count3", wcnt - base, 32'd3);
        check_val("mem0", tb_mem[0], 32'hAAAA_0001);
        check_val("mem2", tb_mem[2], 32'hCCCC_0003);
        use_ovr = 1'b0; cpu_pc = 32'h4; #1;
        check_val("fetch_loaded", cpu_instr, 32'hBBBB_0002);

        // Illegal lengths
        load_start = 1'b1; load_len = 7'd0;
        step();
        load_start = 1'b0;
        check_val("lerr_len0", {31'd0, load_err}, 32'd1);
        check_val("lerr0_stall", {31'd0, cpu_stall}, 32'd0);
        load_start = 1'b1; load_len = 7'd65;
        step();
        load_start = 1'b0;
        check_val("lerr65_ready", {31'd0, ld_ready}, 32'd0);
        check_val("lerr65_stall", {31'd0, cpu_stall}, 32'd0);

        // Full-depth load with valid held high
        base = wcnt;
        load_start = 1'b1; load_len = 7'd64;
        step();
        load_start = 1'b0;
        check_val("lerr_clr", {31'd0, load_err}, 32'd0);
        ld_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ld_data = 32'h1000 + i;
            step();
        end
        check_val("full_done", {31'd0, load_done}, 32'd1);
        check_val("full_count", wcnt - base, 32'd64);
        check_val("full_last_addr", {26'd0, mem_waddr}, 32'd63);
        step();
        ld_valid = 1'b0;
        check_val("full_done_off", {31'd0, load_done}, 32'd0);
        diffs = 0;
        for (int i = 0; i < 64; i++) begin
            if (tb_mem[i] !== 32'h1000 + i) diffs++;
        end
        check_val("full_contents", diffs, 32'd0);

        // Reset mid-load
        base = wcnt;
        load_start = 1'b1; load_len = 7'd10;
        step();
        load_start = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ld_data = 32'h2000 + i;
            step();
        end
        ld_valid = 1'b0;
        rst_n = 1'b0; #1;
        check_val("abort_stall", {31'd0, cpu_stall}, 32'd0);
        check_val("abort_cnt", {26'd0, mem_waddr}, 32'd0);
        check_val("abort_ready", {31'd0, ld_ready}, 32'd0);
        check_val("abort_done", {31'd0, load_done}, 32'd0);
        check_val("abort_writes", wcnt - base, 32'd5);
        step();
        rst_n = 1'b1;
        step();
        check_val("abort_done2", {31'd0, load_done}, 32'd0);
        check_val("abort_mem5", tb_mem[5], 32'h1005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
